// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared packet-state encoding, debug bit positions and default widths
package arbiter_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_t;
  localparam int DBG_OUT_PKT   = 16;
  localparam int DBG_SAT_IN    = 17;
  localparam int DBG_SAT_OUT   = 18;
  localparam int DBG_ECHO_LSB  = 24;
  localparam int DEF_NUM_IN    = 5;
  localparam int DEF_CNT_WIDTH = 32;
  localparam int DEF_REG_WIDTH = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with clear-and-add and a sticky saturation flag
module sat_counter #(
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INC_WIDTH-1:0] i_inc,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_sat
);
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_sat;
  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_next;
  assign w_sum   = {1'b0, i_clear ? '0 : r_count} + (CNT_WIDTH+1)'(i_inc);
  assign w_next  = w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
  assign o_count = r_count;
  assign o_sat   = r_sat;
  // Clear keeps this cycle's increment; the flag follows the post-update count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_sat   <= (~i_clear & r_sat) | (&w_next);
    end
endmodule

// File: rtl/arbiter_pkt_stats.sv
// arbiter_pkt_stats: packet counters, flip and debug status words for the input arbiter
module arbiter_pkt_stats
  import arbiter_pkg::*;
#(
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IN-1:0]    in_tvalid,
  input  logic [NUM_IN-1:0]    in_tready,
  input  logic [NUM_IN-1:0]    in_tlast,
  input  logic                 out_tvalid,
  input  logic                 out_tready,
  input  logic                 out_tlast,
  input  logic                 counterin_clear,
  input  logic                 counterout_clear,
  input  logic [REG_WIDTH-1:0] cpu2ip_flip,
  input  logic [REG_WIDTH-1:0] cpu2ip_debug,
  output logic [CNT_WIDTH-1:0] counterin,
  output logic [CNT_WIDTH-1:0] counterout,
  output logic [REG_WIDTH-1:0] ip2cpu_flip,
  output logic [REG_WIDTH-1:0] ip2cpu_debug
);
  localparam int INC_W = $clog2(NUM_IN + 1);
  logic [NUM_IN-1:0]    w_in_end;
  logic [NUM_IN-1:0]    w_in_pkt;
  logic [INC_W-1:0]     w_in_inc;
  logic                 w_out_end;
  logic                 w_sat_in;
  logic                 w_sat_out;
  logic                 w_unused_dbg;
  logic [REG_WIDTH-1:0] w_dbg;
  logic [REG_WIDTH-1:0] r_flip;
  logic [7:0]           r_echo;
  pkt_state_t           r_out_st;
  genvar i;
  generate
    for (i = 0; i < NUM_IN; i++) begin : g_port
      pkt_state_t r_st;
      assign w_in_end[i] = in_tvalid[i] & in_tready[i] & in_tlast[i];
      assign w_in_pkt[i] = (r_st == IN_PKT);
      // Port i is inside a packet between an accepted non-last beat and its TLAST beat
      always_ff @(posedge clk or posedge reset)
        if (reset) r_st <= IDLE;
        else if (in_tvalid[i] & in_tready[i]) r_st <= in_tlast[i] ? IDLE : IN_PKT;
    end
  endgenerate
  // Number of input ports finishing a packet this cycle
  always_comb begin
    w_in_inc = '0;
    for (int k = 0; k < NUM_IN; k++) w_in_inc = w_in_inc + INC_W'(w_in_end[k]);
  end
  assign w_out_end = out_tvalid & out_tready & out_tlast;
  sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_cnt_in (
    .clk,
    .reset,
    .i_inc   (w_in_inc),
    .i_clear (counterin_clear),
    .o_count (counterin),
    .o_sat   (w_sat_in)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_cnt_out (
    .clk,
    .reset,
    .i_inc   (INC_W'(w_out_end)),
    .i_clear (counterout_clear),
    .o_count (counterout),
    .o_sat   (w_sat_out)
  );
  // Output port packet-state tracker
  always_ff @(posedge clk or posedge reset)
    if (reset) r_out_st <= IDLE;
    else if (out_tvalid & out_tready) r_out_st <= out_tlast ? IDLE : IN_PKT;
  // Registered CPU flip inverse and debug echo byte
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_flip <= '0;
      r_echo <= '0;
    end else begin
      r_flip <= ~cpu2ip_flip;
      r_echo <= cpu2ip_debug[7:0];
    end
  // Debug status word assembled purely from registered state
  always_comb begin
    w_dbg                     = '0;
    w_dbg[NUM_IN-1:0]         = w_in_pkt;
    w_dbg[DBG_OUT_PKT]        = (r_out_st == IN_PKT);
    w_dbg[DBG_SAT_IN]         = w_sat_in;
    w_dbg[DBG_SAT_OUT]        = w_sat_out;
    w_dbg[DBG_ECHO_LSB +: 8]  = r_echo;
  end
  assign w_unused_dbg = ^cpu2ip_debug[REG_WIDTH-1:8];
  assign ip2cpu_flip  = r_flip;
  assign ip2cpu_debug = w_dbg;
endmodule

// File: tb/tb_arbiter_pkt_stats.sv
// tb_arbiter_pkt_stats: scoreboard bench for two instances (32-bit and 4-bit counters)
module tb_arbiter_pkt_stats;
  localparam int N = 5;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4  = 15;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] in_tvalid = '0, in_tready = '0, in_tlast = '0;
  logic out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;
  logic ci_clr = 1'b0, co_clr = 1'b0;
  logic [31:0] cpu_flip = '0, cpu_dbg = '0;
  logic [31:0] ci, co, fl, db, fl4, db4;
  logic [3:0]  ci4, co4;
  always #5 clk = ~clk;
  arbiter_pkt_stats #(.NUM_IN(N), .CNT_WIDTH(32), .REG_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .counterin_clear(ci_clr), .counterout_clear(co_clr), .cpu2ip_flip(cpu_flip), .cpu2ip_debug(cpu_dbg),
    .counterin(ci), .counterout(co), .ip2cpu_flip(fl), .ip2cpu_debug(db));
  arbiter_pkt_stats #(.NUM_IN(N), .CNT_WIDTH(4), .REG_WIDTH(32)) dut4 (
    .clk(clk), .reset(reset), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .counterin_clear(ci_clr), .counterout_clear(co_clr), .cpu2ip_flip(cpu_flip), .cpu2ip_debug(cpu_dbg),
    .counterin(ci4), .counterout(co4), .ip2cpu_flip(fl4), .ip2cpu_debug(db4));
  typedef struct {
    logic [31:0] ci, co, fl, db, db4;
    logic [3:0]  ci4, co4;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;
  int n_pass = 0, n_tot = 0;
  longint m_ci, m_co, m_ci4, m_co4;
  bit m_si, m_so, m_si4, m_so4, m_outpkt;
  bit [N-1:0] m_inpkt;
  logic [31:0] m_flip;
  logic [7:0] m_echo;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask
  function automatic longint upd(longint cur, bit clr, int inc, longint mx);
    longint t = (clr ? 0 : cur) + inc;
    return t > mx ? mx : t;
  endfunction
  function automatic logic [31:0] mkdbg(bit si, bit so);
    return {m_echo, 5'b0, so, si, m_outpkt, 11'b0, m_inpkt};
  endfunction
  task automatic model_reset();
    m_ci = 0; m_co = 0; m_ci4 = 0; m_co4 = 0;
    m_si = 0; m_so = 0; m_si4 = 0; m_so4 = 0;
    m_inpkt = '0; m_outpkt = 0; m_flip = '0; m_echo = '0;
  endtask
  task automatic step(input logic [N-1:0] v, r, l, input logic ov, orr, ol, cc_i, cc_o);
    exp_t e;
    int inc, oinc;
    @(negedge clk); #1;
    in_tvalid = v; in_tready = r; in_tlast = l;
    out_tvalid = ov; out_tready = orr; out_tlast = ol;
    ci_clr = cc_i; co_clr = cc_o;
    inc  = $countones(v & r & l);
    oinc = int'(ov & orr & ol);
    m_ci  = upd(m_ci, cc_i, inc, MAX32);   m_si  = (!cc_i && m_si)  || m_ci  == MAX32;
    m_ci4 = upd(m_ci4, cc_i, inc, MAX4);   m_si4 = (!cc_i && m_si4) || m_ci4 == MAX4;
    m_co  = upd(m_co, cc_o, oinc, MAX32);  m_so  = (!cc_o && m_so)  || m_co  == MAX32;
    m_co4 = upd(m_co4, cc_o, oinc, MAX4);  m_so4 = (!cc_o && m_so4) || m_co4 == MAX4;
    for (int k = 0; k < N; k++) if (v[k] && r[k]) m_inpkt[k] = !l[k];
    if (ov && orr) m_outpkt = !ol;
    m_flip = ~cpu_flip;
    m_echo = cpu_dbg[7:0];
    e.ci = m_ci[31:0]; e.co = m_co[31:0]; e.ci4 = m_ci4[3:0]; e.co4 = m_co4[3:0];
    e.fl = m_flip; e.db = mkdbg(m_si, m_so); e.db4 = mkdbg(m_si4, m_so4);
    q.push_back(e);
    @(posedge clk); #1;
  endtask
  task automatic idle();
    step('0, '0, '0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_async_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_rst counterin", ci, 0);
    chk("async_rst counterout", co, 0);
    chk("async_rst flip", fl, 0);
    chk("async_rst debug", db, 0);
    chk("async_rst counterin4", {28'b0, ci4}, 0);
    chk("async_rst counterout4", {28'b0, co4}, 0);
    chk("async_rst debug4", db4, 0);
    model_reset();
    in_tvalid = '0; out_tvalid = 1'b0; ci_clr = 1'b0; co_clr = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask
  // Scoreboard monitor: compare every expected entry once its cycle has completed
  always @(negedge clk)
    while (q.size() != 0) begin
      e_mon = q.pop_front();
      chk("sb counterin", ci, e_mon.ci);
      chk("sb counterout", co, e_mon.co);
      chk("sb flip", fl, e_mon.fl);
      chk("sb debug", db, e_mon.db);
      chk("sb counterin4", {28'b0, ci4}, {28'b0, e_mon.ci4});
      chk("sb counterout4", {28'b0, co4}, {28'b0, e_mon.co4});
      chk("sb debug4", db4, e_mon.db4);
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    model_reset();
    #2 reset = 1'b1;
    #1;
    chk("reset counterin", ci, 0);
    chk("reset counterout", co, 0);
    chk("reset flip", fl, 0);
    chk("reset debug", db, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++) step(5'h01, 5'h01, (b == 3) ? 5'h01 : 5'h00, 0, 0, 0, 0, 0);
    for (int p = 0; p < 2; p++) step(5'h08, 5'h08, 5'h08, 0, 0, 0, 0, 0);
    chk("pkts counterin", ci, 5);
    chk("pkts counterout", co, 0);
    chk("pkts debug", db, 0);
    step(5'h1f, 5'h1f, 5'h1f, 0, 0, 0, 0, 0);
    chk("burst5 counterin", ci, 10);
    step(5'h1f, 5'h1b, 5'h1f, 0, 0, 0, 0, 0);
    chk("burst4 counterin", ci, 14);
    step(5'h1f, 5'h1f, 5'h1f, 0, 0, 0, 1, 0);
    step(5'h03, 5'h03, 5'h03, 0, 0, 0, 0, 0);
    chk("pre_clear counterin", ci, 7);
    step(5'h03, 5'h03, 5'h03, 0, 0, 0, 1, 0);
    chk("clear_plus_events counterin", ci, 2);
    for (int k = 0; k < 17; k++) step('0, '0, '0, 1, 1, 1, 0, 0);
    chk("sat counterout4", {28'b0, co4}, 15);
    chk("sat debug4 bit18", {31'b0, db4[18]}, 1);
    chk("sat counterout32", co, 17);
    step('0, '0, '0, 0, 0, 0, 0, 1);
    chk("sat_clear counterout4", {28'b0, co4}, 0);
    chk("sat_clear debug4 bit18", {31'b0, db4[18]}, 0);
    step(5'h02, 5'h02, 5'h00, 0, 0, 0, 0, 0);
    chk("midpkt debug bit1", {31'b0, db[1]}, 1);
    do_async_reset();
    step(5'h02, 5'h02, 5'h02, 0, 0, 0, 0, 0);
    chk("post_reset tail counterin", ci, 1);
    chk("post_reset debug bit1", {31'b0, db[1]}, 0);
    cpu_flip = 32'h0000FFFF;
    cpu_dbg  = 32'h000000A5;
    idle();
    chk("flip value", fl, 32'hFFFF0000);
    chk("debug echo", {24'b0, db[31:24]}, 32'hA5);
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        cpu_flip = $urandom;
        cpu_dbg  = $urandom;
      end
      if (c == 1500) do_async_reset();
      step(N'($urandom), N'($urandom | $urandom), N'($urandom & $urandom),
           1'($urandom), 1'($urandom | $urandom), 1'($urandom & $urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end
    idle();
    @(negedge clk); #1;
    if (q.size() != 0) chk("scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
